hilo_mul_sequencer: RTL and testbench
=====================================

Name: hilo_mul_sequencer

Overview:
- Multi-cycle controller for the HI/LO multiply path of the MIPS pipeline.
- Accepts MULT/MULTU/MADD/MSUB/MTHI/MTLO from EX and runs a 32-step radix-2 shift-add multiply.
- Owns the architectural HI/LO registers.
- Drives a stall to the hazard logic while a result is pending, so the single-cycle ALU never produces 64-bit products.

Parameters:
- WIDTH, 32, operand and HI/LO register width.
- STEPS, WIDTH, number of RUN iterations (one multiplier bit per cycle).

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-low reset.
- Start  in  1  request pulse; sampled only in IDLE.
- Op  in  3  operation code (see Behaviour).
- A  in  WIDTH  rs operand (multiplicand; MTHI/MTLO source).
- B  in  WIDTH  rt operand (multiplier).
- Flush  in  1  cancel in-flight operation (branch/exception squash).
- ReadHiLo  in  1  EX/ID currently holds MFHI/MFLO.
- Busy  out  1  high whenever state != IDLE.
- Done  out  1  one-cycle pulse when HI/LO committed by a multiply op.
- Stall  out  1  combinational: ReadHiLo & Busy.
- Hi  out  WIDTH  HI register.
- Lo  out  WIDTH  LO register.

Behaviour:
- Op encoding:
  - 000 MULT, 001 MULTU, 010 MADD (signed), 011 MSUB (signed), 100 MTHI, 101 MTLO.
  - 110/111 are illegal: Start with them is ignored, no state change.
- Reset (Reset==0 at a rising edge):
  - state=IDLE; Hi=Lo=0; Busy=0; Done=0; internal accumulators cleared.
  - Applies mid-operation: the operation is abandoned and no Done is issued.
- States:
  - IDLE: Start & !Flush & Op in {000..011} -> RUN. Latch |A|, |B| (magnitudes for signed ops), result sign = A[31]^B[31] (signed ops only), Op, step counter=0, 64-bit product=0.
  - IDLE: Start & !Flush & Op==MTHI -> Hi<=A at that edge. Op==MTLO -> Lo<=A. No Busy, no Done.
  - RUN: each cycle, if multiplier LSB then product += multiplicand<<counter (or shift-right-accumulate equivalent). Counter increments. When counter==STEPS-1 -> COMMIT.
  - COMMIT: negate the 64-bit product if the sign flag is set. Then:
    - MULT/MULTU: {Hi,Lo} <= product.
    - MADD: {Hi,Lo} <= {Hi,Lo} + product, mod 2^64.
    - MSUB: {Hi,Lo} <= {Hi,Lo} - product, mod 2^64.
    - Done=1 for exactly the following cycle; state -> IDLE.
- Latency:
  - Start sampled at edge E0; Busy=1 from E0 to E(STEPS+1).
  - HI/LO update at E(STEPS+1) = E33, and Done is high in the cycle after E33.
  - Back-to-back Start is accepted in the Done cycle.
- Start while Busy: ignored, never queued. EX must hold the request under Stall.
- Flush:
  - In RUN/COMMIT: next edge -> IDLE; HI/LO unchanged; no Done.
  - Flush has priority over commit in the same cycle.
  - Flush with Start in IDLE: Start ignored, including MTHI/MTLO.
- Stall is purely combinational; it is never asserted in IDLE, including the Done cycle.
- Arithmetic:
  - MULTU treats operands as unsigned.
  - Signed operands use two's-complement magnitude; 0x80000000 magnitude = 2^31 handled in a WIDTH-bit unsigned register.
  - Zero operand still takes the full STEPS cycles (no early exit).

Decomposition:
- Package hilo_pkg: WIDTH default, Op code constants (OP_MULT..OP_MTLO), state enum {IDLE, RUN, COMMIT}.
- One sub-module, shift_add_mul_step: combinational single-iteration product/multiplier update, instantiated once inside the sequencer.
- The FSM, sign handling, HI/LO registers and accumulate logic stay in the top.

Test Plan:
- Reset low 2 cycles, then MTHI A=0x12345678, then MTLO A=0x9ABCDEF0 -> Hi=0x12345678, Lo=0x9ABCDEF0 on the next cycle; Busy never rises.
- MULT A=0xFFFFFFFD (-3), B=5 -> Done 33 cycles after Start; Hi=0xFFFFFFFF, Lo=0xFFFFFFF1.
- MULTU A=B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001. Separately, MULT A=B=0x80000000 -> Hi=0x40000000, Lo=0.
- MTLO 0x10, then MADD A=4, B=4 -> Lo=0x20, Hi=0. Then MSUB A=1, B=0x21 -> Hi=Lo=0xFFFFFFFF.
- MULT A=7, B=9 with Flush at cycle 10 -> Busy low next cycle, no Done, Hi/Lo keep prior values. A Start during RUN is ignored, and a later op completes correctly.
- Start MULT, hold ReadHiLo=1 -> Stall=1 for all 33 Busy cycles, 0 in the Done cycle. Reset low at cycle 15 -> Hi=Lo=0, Busy=0, no Done.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply sequencer: default width,
// operation codes and the sequencer state encoding.
package hilo_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_MADD  = 3'b010;
    localparam logic [2:0] OP_MSUB  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // MULTU is the only multiply that treats its operands as unsigned.
    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

endpackage

// File: rtl/shift_add_mul_step.sv
// One radix-2 shift-add iteration. The product register starts as
// {0, multiplier}; each step conditionally adds the multiplicand into the
// upper half and shifts the whole register right by one, so after WIDTH
// steps it holds the full 2*WIDTH-bit unsigned product.
module shift_add_mul_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] prod,
    input  logic [WIDTH-1:0]   mcand,
    output logic [2*WIDTH-1:0] prod_next
);

    logic [WIDTH:0] sum;

    // Add the multiplicand when the current multiplier bit is set, then shift.
    always_comb begin
        sum       = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
        prod_next = {sum, prod[WIDTH-1:1]};
    end

endmodule

// File: rtl/hilo_mul_sequencer.sv
// Multi-cycle HI/LO multiply controller. Owns the architectural HI/LO
// registers, runs MULT/MULTU/MADD/MSUB as a STEPS-cycle shift-add on operand
// magnitudes and stalls MFHI/MFLO readers while a result is pending.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no operation in flight; Start accepted, MTHI/MTLO applied
//   RUN    | one multiplier bit consumed per cycle
//   COMMIT | sign fix-up and HI/LO write (or accumulate), Done next cycle
module hilo_mul_sequencer
    import hilo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int STEPS = WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Flush,
    input  logic             ReadHiLo,
    output logic             Busy,
    output logic             Done,
    output logic             Stall,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [WIDTH-1:0]     mcand;
    logic [2*WIDTH-1:0]   prod;
    logic [2*WIDTH-1:0]   prod_next;
    logic                 neg;
    logic [2:0]           op_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
    logic                 done_q;

    logic                 op_signed;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [2*WIDTH-1:0]   prod_signed;
    logic [2*WIDTH-1:0]   commit_val;

    shift_add_mul_step #(.WIDTH(WIDTH)) u_step (
        .prod      (prod),
        .mcand     (mcand),
        .prod_next (prod_next)
    );

    // Operand magnitudes for the request on the inputs; 0x80..0 stays 2^(W-1) unsigned.
    always_comb begin
        op_signed = is_signed_op(Op);
        mag_a     = (op_signed && A[WIDTH-1]) ? (~A + 1'b1) : A;
        mag_b     = (op_signed && B[WIDTH-1]) ? (~B + 1'b1) : B;
    end

    // Signed fix-up of the finished product and the accumulate/overwrite choice.
    always_comb begin
        prod_signed = neg ? (~prod + 1'b1) : prod;
        case (op_q)
            OP_MADD: commit_val = {hi_q, lo_q} + prod_signed;
            OP_MSUB: commit_val = {hi_q, lo_q} - prod_signed;
            default: commit_val = prod_signed;
        endcase
    end

    // Sequencer FSM with the HI/LO registers; Flush always wins over commit.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state  <= IDLE;
            cnt    <= '0;
            mcand  <= '0;
            prod   <= '0;
            neg    <= 1'b0;
            op_q   <= OP_MULT;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start && !Flush) begin
                        if (!Op[2]) begin
                            state <= RUN;
                            mcand <= mag_a;
                            // Low half doubles as the multiplier shift register.
                            prod  <= {{WIDTH{1'b0}}, mag_b};
                            neg   <= op_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                            op_q  <= Op;
                            cnt   <= '0;
                        end else if (Op == OP_MTHI) begin
                            hi_q <= A;
                        end else if (Op == OP_MTLO) begin
                            lo_q <= A;
                        end
                    end
                end
                RUN: begin
                    if (Flush) begin
                        state <= IDLE;
                    end else begin
                        prod <= prod_next;
                        cnt  <= cnt + CNT_W'(1);
                        if (cnt == LAST) begin
                            state <= COMMIT;
                        end
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                    if (!Flush) begin
                        {hi_q, lo_q} <= commit_val;
                        done_q       <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Busy  = (state != IDLE);
    assign Stall = ReadHiLo & Busy;
    assign Done  = done_q;
    assign Hi    = hi_q;
    assign Lo    = lo_q;

endmodule

// File: tb/tb_hilo_mul_sequencer.sv
// Directed bench for hilo_mul_sequencer: MTHI/MTLO, signed/unsigned
// multiplies, accumulate, flush, stall and mid-operation reset.
module tb_hilo_mul_sequencer;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_MADD  = 3'b010;
    localparam logic [2:0] OP_MSUB  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_BAD   = 3'b110;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Flush;
    logic        ReadHiLo;
    logic        Busy;
    logic        Done;
    logic        Stall;
    logic [31:0] Hi;
    logic [31:0] Lo;

    int tests = 0;
    int fails = 0;
    int cyc, busy_n, stall_n, done_n;

    hilo_mul_sequencer dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .Op       (Op),
        .A        (A),
        .B        (B),
        .Flush    (Flush),
        .ReadHiLo (ReadHiLo),
        .Busy     (Busy),
        .Done     (Done),
        .Stall    (Stall),
        .Hi       (Hi),
        .Lo       (Lo)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // Present a one-cycle request; returns at the negedge after it was sampled.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1;
        Op    = op;
        A     = a;
        B     = b;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    // Cycles from the sampling edge until Done, with Busy/Stall occupancy.
    task automatic wait_done(output int c, output int bn, output int sn);
        c  = 0;
        bn = 0;
        sn = 0;
        while (Done !== 1'b1 && c < 100) begin
            if (Busy === 1'b1) bn++;
            if (Stall === 1'b1) sn++;
            @(negedge Clk);
            c++;
        end
    endtask

    initial begin
        Reset    = 1'b0;
        Start    = 1'b0;
        Op       = OP_MULT;
        A        = '0;
        B        = '0;
        Flush    = 1'b0;
        ReadHiLo = 1'b0;

        step(2);
        check("rst_hi", Hi, 0);
        check("rst_lo", Lo, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        Reset = 1'b1;
        step(1);

        issue(OP_MTHI, 32'h12345678, 0);
        check("mthi_hi", Hi, 32'h12345678);
        check("mthi_busy", Busy, 0);
        issue(OP_MTLO, 32'h9ABCDEF0, 0);
        check("mtlo_lo", Lo, 32'h9ABCDEF0);
        check("mtlo_hi", Hi, 32'h12345678);
        check("mtlo_busy", Busy, 0);
        check("mtlo_done", Done, 0);

        issue(OP_MULT, 32'hFFFFFFFD, 32'd5);
        wait_done(cyc, busy_n, stall_n);
        check("mult_lat", cyc, 33);
        check("mult_busy_cycles", busy_n, 33);
        check("mult_hilo", {Hi, Lo}, 64'hFFFFFFFF_FFFFFFF1);
        check("mult_busy_done", Busy, 0);
        step(1);
        check("mult_done_pulse", Done, 0);

        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(cyc, busy_n, stall_n);
        check("multu_lat", cyc, 33);
        check("multu_hilo", {Hi, Lo}, 64'hFFFFFFFE_00000001);

        issue(OP_MULT, 32'h80000000, 32'h80000000);
        wait_done(cyc, busy_n, stall_n);
        check("mult_min_lat", cyc, 33);
        check("mult_min_hilo", {Hi, Lo}, 64'h40000000_00000000);

        issue(OP_MTHI, 0, 0);
        issue(OP_MTLO, 32'h10, 0);
        issue(OP_MADD, 32'd4, 32'd4);
        wait_done(cyc, busy_n, stall_n);
        check("madd_lat", cyc, 33);
        check("madd_hilo", {Hi, Lo}, 64'h00000000_00000020);
        issue(OP_MSUB, 32'd1, 32'h21);
        check("b2b_busy", Busy, 1);
        check("b2b_done_low", Done, 0);
        wait_done(cyc, busy_n, stall_n);
        check("msub_lat", cyc, 33);
        check("msub_hilo", {Hi, Lo}, 64'hFFFFFFFF_FFFFFFFF);

        issue(OP_MULT, 32'd7, 32'd9);
        step(4);
        issue(OP_MTHI, 32'hDEADBEEF, 0);
        check("start_in_run_busy", Busy, 1);
        step(4);
        Flush = 1'b1;
        @(negedge Clk);
        Flush = 1'b0;
        check("flush_busy", Busy, 0);
        check("flush_done", Done, 0);
        check("flush_hilo", {Hi, Lo}, 64'hFFFFFFFF_FFFFFFFF);
        done_n = 0;
        for (int i = 0; i < 3; i++) begin
            if (Busy === 1'b1 || Done === 1'b1) done_n++;
            @(negedge Clk);
        end
        check("flush_no_queue", done_n, 0);

        Flush = 1'b1;
        issue(OP_MTHI, 32'h55555555, 0);
        Flush = 1'b0;
        check("flush_idle_mthi", Hi, 32'hFFFFFFFF);
        issue(OP_BAD, 32'h11111111, 32'h2);
        check("illegal_busy", Busy, 0);
        check("illegal_hilo", {Hi, Lo}, 64'hFFFFFFFF_FFFFFFFF);

        ReadHiLo = 1'b1;
        check("stall_idle", Stall, 0);
        issue(OP_MULT, 32'd7, 32'd9);
        wait_done(cyc, busy_n, stall_n);
        check("stall_lat", cyc, 33);
        check("stall_cycles", stall_n, 33);
        check("stall_done_cycle", Stall, 0);
        check("after_flush_hilo", {Hi, Lo}, 64'h00000000_0000003F);
        ReadHiLo = 1'b0;

        issue(OP_MULT, 32'd2, 32'd3);
        step(14);
        Reset = 1'b0;
        @(negedge Clk);
        check("midrst_hilo", {Hi, Lo}, 0);
        check("midrst_busy", Busy, 0);
        check("midrst_done", Done, 0);
        Reset = 1'b1;
        done_n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (Done === 1'b1 || Busy === 1'b1) done_n++;
        end
        check("midrst_no_done", done_n, 0);
        check("midrst_hilo_after", {Hi, Lo}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
